i2c_cmd_arbiter: RTL and testbench



---
 rtl/i2c_cmd_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_i2c_cmd_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter that shares one I2C_Controller write engine between
// NREQ requesters. Generates the controller work clock, issues the latched
// 24-bit word, retries on NACK, aborts on a missing END and returns a
// per-requester done/err strobe.
module i2c_cmd_arbiter #(
    parameter int CLK_Freq  = 50000000,
    parameter int I2C_Freq  = 20000,
    parameter int NREQ      = 2,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 64
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic [NREQ-1:0]      i_req,
    input  logic [24*NREQ-1:0]   i_data,
    output logic [NREQ-1:0]      o_gnt,
    output logic [NREQ-1:0]      o_done,
    output logic [NREQ-1:0]      o_err,
    output logic                 o_busy,
    output logic                 o_ctrl_clk,
    output logic [23:0]          o_i2c_data,
    output logic                 o_i2c_go,
    input  logic                 i_i2c_end,
    input  logic                 i_i2c_ack
);

    localparam int DIV    = CLK_Freq / (2 * I2C_Freq);
    localparam int CntW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int ToW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int PtrW   = $clog2(NREQ);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWait,
        StDone,
        StFail
    } state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              clk_q, clk_d;
    logic              cnt_wrap;
    logic              tick;

    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [23:0]       data_q, data_d;
    logic              go_q, go_d;
    logic [PtrW-1:0]   rr_q, rr_d;
    logic [PtrW-1:0]   win_q, win_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [ToW-1:0]    to_q, to_d;

    logic              hi_found;
    logic [PtrW-1:0]   hi_idx, lo_idx, pick;
    logic [23:0]       pick_word;

    // Decoded FSM events, shared by next-state and datapath logic.
    logic ev_grant, ev_start, ev_ack, ev_retry, ev_nack_fail, ev_timeout, ev_wait_inc, ev_finish;

    assign cnt_wrap = (cnt_q == CntW'(DIV - 1));
    // Last cycle of the high phase: the work clock falls on the next edge.
    assign tick     = cnt_wrap && clk_q;

    // Work-clock divider next state.
    always_comb begin
        cnt_d = cnt_wrap ? '0 : cnt_q + CntW'(1);
        clk_d = cnt_wrap ? ~clk_q : clk_q;
    end

    // Winner search: lowest requesting index at or above rr_q, else lowest overall.
    always_comb begin
        hi_found  = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                lo_idx = PtrW'(k);
                if (PtrW'(k) >= rr_q) begin
                    hi_idx   = PtrW'(k);
                    hi_found = 1'b1;
                end
            end
        end
        pick      = hi_found ? hi_idx : lo_idx;
        pick_word = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (PtrW'(k) == pick) begin
                pick_word = i_data[24*k +: 24];
            end
        end
    end

    // Event decode from state, tick and controller handshake.
    always_comb begin
        ev_grant     = (state_q == StIdle) && tick && (|i_req);
        ev_start     = (state_q == StStart) && tick;
        ev_ack       = (state_q == StWait) && tick && i_i2c_end && !i_i2c_ack;
        ev_nack_fail = (state_q == StWait) && tick && i_i2c_end && i_i2c_ack &&
                       (retry_q == RetryW'(MAX_RETRY));
        ev_retry     = (state_q == StWait) && tick && i_i2c_end && i_i2c_ack &&
                       (retry_q != RetryW'(MAX_RETRY));
        ev_timeout   = (state_q == StWait) && tick && !i_i2c_end &&
                       (to_q == ToW'(TIMEOUT - 1));
        ev_wait_inc  = (state_q == StWait) && tick && !i_i2c_end &&
                       (to_q != ToW'(TIMEOUT - 1));
        ev_finish    = (state_q == StDone) || (state_q == StFail);
    end

    // State register.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ev_grant) state_d = StStart;
            StStart: if (ev_start) state_d = StWait;
            StWait: begin
                if (ev_ack) begin
                    state_d = StDone;
                end else if (ev_nack_fail || ev_timeout) begin
                    state_d = StFail;
                end else if (ev_retry) begin
                    state_d = StStart;
                end
            end
            StDone:  state_d = StIdle;
            StFail:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next state: grant, word latch, GO, counters and round-robin pointer.
    always_comb begin
        gnt_d   = gnt_q;
        data_d  = data_q;
        go_d    = go_q;
        rr_d    = rr_q;
        win_d   = win_q;
        retry_d = retry_q;
        to_d    = to_q;
        if (ev_grant) begin
            data_d  = pick_word;
            win_d   = pick;
            gnt_d   = NREQ'(1) << pick;
            retry_d = '0;
            to_d    = '0;
        end
        if (ev_start) begin
            go_d = 1'b1;
            to_d = '0;
        end
        if (ev_ack || ev_nack_fail || ev_retry || ev_timeout) begin
            go_d = 1'b0;
        end
        if (ev_retry) begin
            retry_d = retry_q + RetryW'(1);
        end
        if (ev_wait_inc) begin
            to_d = to_q + ToW'(1);
        end
        if (ev_finish) begin
            gnt_d = '0;
            rr_d  = (win_q == PtrW'(NREQ - 1)) ? '0 : win_q + PtrW'(1);
        end
    end

    // Datapath and divider registers.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            gnt_q   <= '0;
            data_q  <= '0;
            go_q    <= 1'b0;
            rr_q    <= '0;
            win_q   <= '0;
            retry_q <= '0;
            to_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            clk_q   <= clk_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            go_q    <= go_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            retry_q <= retry_d;
            to_q    <= to_d;
        end
    end

    // Outputs decoded from state; strobes last exactly the DONE/FAIL cycle.
    always_comb begin
        o_busy = (state_q != StIdle);
        o_done = (state_q == StDone) ? gnt_q : '0;
        o_err  = (state_q == StFail) ? gnt_q : '0;
    end

    assign o_gnt      = gnt_q;
    assign o_ctrl_clk = clk_q;
    assign o_i2c_data = data_q;
    assign o_i2c_go   = go_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Self-checking bench for i2c_cmd_arbiter: directed scenarios followed by
// randomized request/controller behaviour, checked against a transaction-level
// model (round-robin pick, attempt count, strobe latency in ticks).
module tb_i2c_cmd_arbiter;

    localparam int CLK_FREQ  = 200;
    localparam int I2C_FREQ  = 20;
    localparam int NREQ      = 2;
    localparam int MAX_RETRY = 2;
    localparam int TIMEOUT   = 8;
    localparam int DIV       = CLK_FREQ / (2 * I2C_FREQ);
    localparam int TPER      = 2 * DIV;   // iCLK cycles per tick
    localparam int END_TICKS = 3;         // controller answers END after this many ticks

    logic                iCLK = 1'b0;
    logic                iRST = 1'b1;
    logic [NREQ-1:0]     i_req = '0;
    logic [24*NREQ-1:0]  i_data = '0;
    logic [NREQ-1:0]     o_gnt, o_done, o_err;
    logic                o_busy, o_ctrl_clk, o_i2c_go;
    logic [23:0]         o_i2c_data;
    logic                i_i2c_end = 1'b0;
    logic                i_i2c_ack = 1'b0;

    i2c_cmd_arbiter #(
        .CLK_Freq  (CLK_FREQ),
        .I2C_Freq  (I2C_FREQ),
        .NREQ      (NREQ),
        .MAX_RETRY (MAX_RETRY),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .i_req      (i_req),
        .i_data     (i_data),
        .o_gnt      (o_gnt),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_busy     (o_busy),
        .o_ctrl_clk (o_ctrl_clk),
        .o_i2c_data (o_i2c_data),
        .o_i2c_go   (o_i2c_go),
        .i_i2c_end  (i_i2c_end),
        .i_i2c_ack  (i_i2c_ack)
    );

    always #5 iCLK = ~iCLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    bit [NREQ-1:0] pend = '0;
    logic [23:0]   words [NREQ];
    int            rr = 0;

    // Controller model state.
    int  cyc = 0;
    int  rises = 0;
    int  nack_left = 0;
    bit  no_end = 1'b0;
    logic prev_go = 1'b0;
    logic prev_cclk = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // One iCLK cycle; sample at negedge and run the controller model.
    task automatic step();
        @(negedge iCLK);
        cyc++;
        if (!o_i2c_go) begin
            i_i2c_end = 1'b0;
            i_i2c_ack = 1'b0;
        end else begin
            if (!prev_go) rises = 0;
            if (!i_i2c_end && !no_end) begin
                if (o_ctrl_clk && !prev_cclk) rises++;
                if (rises == END_TICKS) begin
                    i_i2c_end = 1'b1;
                    i_i2c_ack = (nack_left > 0);
                    if (nack_left > 0) nack_left--;
                end
            end
        end
        prev_go   = o_i2c_go;
        prev_cclk = o_ctrl_clk;
    endtask

    function automatic int pick(input bit [NREQ-1:0] p, input int ptr);
        for (int i = 0; i < NREQ; i++) begin
            if (p[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return 0;
    endfunction

    task automatic post(input int k, input logic [23:0] wd);
        words[k]          = wd;
        i_data[24*k +: 24] = wd;
        pend[k]           = 1'b1;
        i_req[k]          = 1'b1;
    endtask

    // One complete transfer: arbitration, attempts, strobe and release.
    // rearm: 0 never, 1 always, 2 random re-assertion right after the strobe.
    task automatic run_transfer(input bit rnd, input int nack, input bit noend, input int rearm);
        int   w, wait_n, gnt_cyc, first_go, pulses, low_run, attempts, exp_delay;
        bit   ok, do_rearm;
        logic pg;
        wait_n = 0;
        while (o_gnt == '0 && wait_n < 3 * TPER) begin
            step();
            wait_n++;
        end
        check("gnt_seen", 32'(o_gnt != '0), 1);
        if (o_gnt == '0) return;
        w = pick(pend, rr);
        check("gnt", 32'(o_gnt), 32'(1) << w);
        check("data", 32'(o_i2c_data), 32'(words[w]));
        check("busy", 32'(o_busy), 1);
        gnt_cyc = cyc;
        if (rnd) begin
            case ($urandom_range(0, 3))
                0: begin nack = 0; noend = 1'b0; end
                1: begin nack = 1; noend = 1'b0; end
                2: begin nack = 99; noend = 1'b0; end
                default: begin nack = 0; noend = 1'b1; end
            endcase
        end
        nack_left = nack;
        no_end    = noend;
        ok        = !noend && (nack <= MAX_RETRY);
        attempts  = noend ? 1 : ((nack < MAX_RETRY) ? nack : MAX_RETRY) + 1;
        exp_delay = noend ? TIMEOUT * TPER : (END_TICKS + (END_TICKS + 1) * (attempts - 1)) * TPER;
        first_go = -1;
        pulses   = 0;
        low_run  = 0;
        pg       = o_i2c_go;
        wait_n   = 0;
        while ((o_done | o_err) == '0 && wait_n < 400) begin
            step();
            wait_n++;
            if (o_i2c_go && !pg) begin
                pulses++;
                if (first_go < 0) first_go = cyc;
                else check("go_gap", 32'(low_run >= TPER), 1);
            end
            if (!o_i2c_go) low_run++;
            else low_run = 0;
            pg = o_i2c_go;
        end
        check("strobe_seen", 32'((o_done | o_err) != '0), 1);
        if ((o_done | o_err) == '0) return;
        check("go_lat", 32'(first_go - gnt_cyc), 32'(TPER));
        check("strobe_lat", 32'(cyc - first_go), 32'(exp_delay));
        check("go_pulses", 32'(pulses), 32'(attempts));
        check("done", 32'(o_done), ok ? (32'(1) << w) : 32'(0));
        check("err", 32'(o_err), ok ? 32'(0) : (32'(1) << w));
        check("go_low", 32'(o_i2c_go), 0);
        do_rearm = (rearm == 1) || (rearm == 2 && $urandom_range(0, 1) == 1);
        if (do_rearm) begin
            post(w, 24'($urandom()));
        end else begin
            pend[w]  = 1'b0;
            i_req[w] = 1'b0;
        end
        rr = (w + 1) % NREQ;
        step();
        check("strobe_len", 32'({o_done, o_err}), 0);
        check("busy_fall", 32'(o_busy), 0);
        check("gnt_clr", 32'(o_gnt), 0);
    endtask

    initial begin
        int  wait_n;
        bit  saw;
        bit [NREQ-1:0] mask;
        for (int k = 0; k < NREQ; k++) words[k] = '0;
        repeat (3) step();
        check("rst_gnt", 32'(o_gnt), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_err", 32'(o_err), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_go", 32'(o_i2c_go), 0);
        check("rst_data", 32'(o_i2c_data), 0);
        check("rst_cclk", 32'(o_ctrl_clk), 0);
        iRST = 1'b0;

        // Single request, immediate ACK.
        post(0, 24'h341E00);
        run_transfer(1'b0, 0, 1'b0, 0);

        // Reset in the middle of WAIT.
        post(1, 24'h123456);
        no_end = 1'b1;
        wait_n = 0;
        while (!o_i2c_go && wait_n < 6 * TPER) begin
            step();
            wait_n++;
        end
        check("mid_go", 32'(o_i2c_go), 1);
        repeat (5) step();
        iRST = 1'b1;
        step();
        check("mrst_gnt", 32'(o_gnt), 0);
        check("mrst_busy", 32'(o_busy), 0);
        check("mrst_go", 32'(o_i2c_go), 0);
        check("mrst_data", 32'(o_i2c_data), 0);
        check("mrst_cclk", 32'(o_ctrl_clk), 0);
        check("mrst_strobe", 32'({o_done, o_err}), 0);
        iRST  = 1'b0;
        i_req = '0;
        pend  = '0;
        rr    = 0;
        saw   = 1'b0;
        repeat (60) begin
            step();
            if ((o_done | o_err) != '0) saw = 1'b1;
        end
        check("no_strobe_after_rst", 32'(saw), 0);

        // Simultaneous requests from rr=0, req0 re-asserted: grants 01,10,01.
        post(0, 24'h34001A);
        post(1, 24'h340C00);
        run_transfer(1'b0, 0, 1'b0, 1);
        run_transfer(1'b0, 0, 1'b0, 0);
        run_transfer(1'b0, 0, 1'b0, 0);

        // NACK on every attempt, then NACK once, then no END at all.
        post(0, 24'h340A55);
        run_transfer(1'b0, 99, 1'b0, 0);
        post(1, 24'h3412AA);
        run_transfer(1'b0, 1, 1'b0, 0);
        post(0, 24'h340E01);
        run_transfer(1'b0, 0, 1'b1, 0);
        post(1, 24'h340C7F);
        run_transfer(1'b0, 0, 1'b0, 0);

        // Randomized traffic.
        repeat (40) begin
            if (pend == '0) begin
                mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
                for (int k = 0; k < NREQ; k++) begin
                    if (mask[k]) post(k, 24'($urandom()));
                end
            end
            run_transfer(1'b1, 0, 1'b0, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
